// File: rtl/wb_pkg.sv
// Shared widths, lane indexing and lane record type for the Mem/WB register file.
// The lane lookup helper encodes the fixed write-back priority LS > M > A1 > A0.
package wb_pkg;

    localparam int DW    = 16;
    localparam int LSW   = 8;
    localparam int TW    = 5;
    localparam int NREG  = 2 ** TW;
    localparam int NLANE = 4;
    localparam int NRP   = 4;

    // Enum order is the priority order: a later lane overrides an earlier one.
    typedef enum logic [1:0] {LANE_A0, LANE_A1, LANE_M, LANE_LS} lane_e;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } wb_lane_t;

    typedef wb_lane_t [NLANE-1:0] wb_lanes_t;

    // Returns {hit, data} for the highest-priority lane targeting a nonzero addr.
    function automatic logic [DW:0] lane_lookup(input wb_lanes_t lanes,
                                                input logic [TW-1:0] addr);
        logic [DW:0] res;
        res = '0;
        for (int l = 0; l < NLANE; l++) begin
            if (addr != '0 && lanes[l].tag == addr) res = {1'b1, lanes[l].data};
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_regfile_sb_if.sv
// Bus bundle between the Mem/WB stage, issue/decode and the register file.
// master = pipeline side driving lanes/issue/read addresses; slave = register file.
interface wb_regfile_sb_if;
    import wb_pkg::*;

    logic                  wb_en;
    logic [DW-1:0]         a0_wr, a1_wr, m_wr;
    logic [LSW-1:0]        ls_wr;
    logic [TW-1:0]         a0_tag, a1_tag, m_tag, ls_tag;
    logic                  iss_en;
    logic [TW-1:0]         iss_tag;
    logic [TW-1:0]         rd_addr0, rd_addr1, rd_addr2, rd_addr3;
    logic [DW-1:0]         rd_data0, rd_data1, rd_data2, rd_data3;
    logic                  rd_busy0, rd_busy1, rd_busy2, rd_busy3;
    logic                  hazard;
    logic [TW:0]           busy_cnt;

    modport master (
        output wb_en, a0_wr, a1_wr, m_wr, ls_wr, a0_tag, a1_tag, m_tag, ls_tag,
               iss_en, iss_tag, rd_addr0, rd_addr1, rd_addr2, rd_addr3,
        input  rd_data0, rd_data1, rd_data2, rd_data3,
               rd_busy0, rd_busy1, rd_busy2, rd_busy3, hazard, busy_cnt
    );

    modport slave (
        input  wb_en, a0_wr, a1_wr, m_wr, ls_wr, a0_tag, a1_tag, m_tag, ls_tag,
               iss_en, iss_tag, rd_addr0, rd_addr1, rd_addr2, rd_addr3,
        output rd_data0, rd_data1, rd_data2, rd_data3,
               rd_busy0, rd_busy1, rd_busy2, rd_busy3, hazard, busy_cnt
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard: issue sets a destination pending, write-back clears it.
// Set beats clear on the same register because the issuing producer is younger.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_wb_en,
    input  logic [NLANE-1:0][TW-1:0]  i_wb_tag,
    input  logic                      i_iss_en,
    input  logic [TW-1:0]             i_iss_tag,
    input  logic [NRP-1:0][TW-1:0]    i_rd_addr,
    output logic [NRP-1:0]            o_rd_busy,
    output logic [TW:0]               o_busy_cnt
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_busy_nxt;
    logic [TW:0]     r_busy_cnt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_clr = '0;
        w_set = '0;
        if (i_wb_en) begin
            for (int l = 0; l < NLANE; l++) w_clr[i_wb_tag[l]] = 1'b1;
        end
        if (i_iss_en && i_iss_tag != '0) w_set[i_iss_tag] = 1'b1;
        w_busy_nxt = (r_busy & ~w_clr) | w_set;
    end

    always_comb begin
        o_rd_busy = '0;
        for (int p = 0; p < NRP; p++) begin
            o_rd_busy[p] = r_busy[i_rd_addr[p]] & ~w_clr[i_rd_addr[p]];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= (TW+1)'($countones(w_busy_nxt));
        end
    end

    assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/wb_regfile_sb.sv
// Write-back register file: four tagged lanes with fixed priority, four bypassed
// combinational read ports, and per-port busy flags from the scoreboard.
module wb_regfile_sb
    import wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    wb_regfile_sb_if.slave  bus
);

    wb_lanes_t                   w_lane;
    logic [NLANE-1:0][TW-1:0]    w_lane_tag;
    logic [NRP-1:0][TW-1:0]      w_rd_addr;
    logic [DW-1:0]               w_rd_data [NRP];
    logic [NRP-1:0]              w_rd_busy;
    logic [NREG-1:0]             w_wr_en;
    logic [DW-1:0]               w_wr_data [NREG];
    logic [DW-1:0]               r_regs    [NREG];

    always_comb begin
        w_lane[LANE_A0] = '{tag: bus.a0_tag, data: bus.a0_wr};
        w_lane[LANE_A1] = '{tag: bus.a1_tag, data: bus.a1_wr};
        w_lane[LANE_M]  = '{tag: bus.m_tag,  data: bus.m_wr};
        w_lane[LANE_LS] = '{tag: bus.ls_tag, data: DW'(bus.ls_wr)};
        for (int l = 0; l < NLANE; l++) w_lane_tag[l] = w_lane[l].tag;
    end

    assign w_rd_addr = {bus.rd_addr3, bus.rd_addr2, bus.rd_addr1, bus.rd_addr0};

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            {w_wr_en[r], w_wr_data[r]} = bus.wb_en ? lane_lookup(w_lane, TW'(r)) : '0;
        end
    end

    // NOTE: the array is reset because cleared contents are architecturally visible after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (w_wr_en[r]) r_regs[r] <= w_wr_data[r];
            end
        end
    end

    always_comb begin
        logic [DW:0] w_hit;
        for (int p = 0; p < NRP; p++) begin
            w_hit = bus.wb_en ? lane_lookup(w_lane, w_rd_addr[p]) : '0;
            if (w_hit[DW])                 w_rd_data[p] = w_hit[DW-1:0];
            else if (w_rd_addr[p] == '0)   w_rd_data[p] = '0;
            else                           w_rd_data[p] = r_regs[w_rd_addr[p]];
        end
    end

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wb_en    (bus.wb_en),
        .i_wb_tag   (w_lane_tag),
        .i_iss_en   (bus.iss_en),
        .i_iss_tag  (bus.iss_tag),
        .i_rd_addr  (w_rd_addr),
        .o_rd_busy  (w_rd_busy),
        .o_busy_cnt (bus.busy_cnt)
    );

    assign bus.rd_data0 = w_rd_data[0];
    assign bus.rd_data1 = w_rd_data[1];
    assign bus.rd_data2 = w_rd_data[2];
    assign bus.rd_data3 = w_rd_data[3];
    assign bus.rd_busy0 = w_rd_busy[0];
    assign bus.rd_busy1 = w_rd_busy[1];
    assign bus.rd_busy2 = w_rd_busy[2];
    assign bus.rd_busy3 = w_rd_busy[3];
    assign bus.hazard   = |w_rd_busy;

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Directed bench for wb_regfile_sb: expectations are queued as stimulus is applied
// and popped against the DUT outputs mid-cycle (or right after an async reset).
module tb_wb_regfile_sb;
    import wb_pkg::*;

    typedef enum {S_D0, S_D1, S_D2, S_D3, S_B0, S_B1, S_B2, S_B3, S_HAZ, S_CNT} sel_e;
    typedef struct {
        sel_e        sel;
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    wb_regfile_sb_if bus ();

    wb_regfile_sb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            S_D0:    return 32'(bus.rd_data0);
            S_D1:    return 32'(bus.rd_data1);
            S_D2:    return 32'(bus.rd_data2);
            S_D3:    return 32'(bus.rd_data3);
            S_B0:    return 32'(bus.rd_busy0);
            S_B1:    return 32'(bus.rd_busy1);
            S_B2:    return 32'(bus.rd_busy2);
            S_B3:    return 32'(bus.rd_busy3);
            S_HAZ:   return 32'(bus.hazard);
            default: return 32'(bus.busy_cnt);
        endcase
    endfunction

    task automatic expect_v(input sel_e s, input string tag, input logic [31:0] exp);
        exp_t e;
        e.sel = s;
        e.tag = tag;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic idle();
        bus.wb_en  = 1'b0;
        bus.a0_wr  = '0; bus.a1_wr = '0; bus.m_wr = '0; bus.ls_wr = '0;
        bus.a0_tag = '0; bus.a1_tag = '0; bus.m_tag = '0; bus.ls_tag = '0;
        bus.iss_en = 1'b0;
        bus.iss_tag = '0;
    endtask

    task automatic set_addr(input logic [TW-1:0] a0, a1, a2, a3);
        bus.rd_addr0 = a0; bus.rd_addr1 = a1; bus.rd_addr2 = a2; bus.rd_addr3 = a3;
    endtask

    // Compare mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        set_addr(5'd5, 5'd5, 5'd5, 5'd5);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        expect_v(S_D0, "rst_d0", 0); expect_v(S_D1, "rst_d1", 0);
        expect_v(S_D2, "rst_d2", 0); expect_v(S_D3, "rst_d3", 0);
        expect_v(S_B0, "rst_b0", 0); expect_v(S_B1, "rst_b1", 0);
        expect_v(S_B2, "rst_b2", 0); expect_v(S_B3, "rst_b3", 0);
        expect_v(S_HAZ, "rst_haz", 0); expect_v(S_CNT, "rst_cnt", 0);
        tick();

        // Issue 7: busy is not visible in the issue cycle
        set_addr(5'd7, 5'd0, 5'd0, 5'd0);
        bus.iss_en = 1'b1; bus.iss_tag = 5'd7;
        expect_v(S_B0, "iss7_same_b0", 0); expect_v(S_CNT, "iss7_same_cnt", 0);
        tick();
        idle();
        expect_v(S_B0, "iss7_b0", 1); expect_v(S_HAZ, "iss7_haz", 1);
        expect_v(S_CNT, "iss7_cnt", 1);
        tick();
        bus.wb_en = 1'b1; bus.m_tag = 5'd7; bus.m_wr = 16'hBEEF;
        expect_v(S_D0, "wb7_byp_d0", 32'hBEEF); expect_v(S_B0, "wb7_byp_b0", 0);
        expect_v(S_HAZ, "wb7_byp_haz", 0); expect_v(S_CNT, "wb7_cnt_lag", 1);
        tick();
        idle();
        expect_v(S_D0, "wb7_stored", 32'hBEEF); expect_v(S_CNT, "wb7_cnt", 0);
        tick();

        // Lane priority on tag 3
        set_addr(5'd0, 5'd3, 5'd0, 5'd0);
        bus.wb_en = 1'b1;
        bus.a0_tag = 5'd3; bus.a1_tag = 5'd3; bus.m_tag = 5'd3; bus.ls_tag = 5'd3;
        bus.a0_wr = 16'h1111; bus.a1_wr = 16'h2222; bus.m_wr = 16'h3333; bus.ls_wr = 8'hAB;
        expect_v(S_D1, "prio_all_byp", 32'h00AB);
        tick();
        idle();
        expect_v(S_D1, "prio_all_stored", 32'h00AB);
        tick();
        bus.wb_en = 1'b1;
        bus.a0_tag = 5'd3; bus.a1_tag = 5'd3; bus.a0_wr = 16'h1111; bus.a1_wr = 16'h2222;
        expect_v(S_D1, "prio_a1a0_byp", 32'h2222);
        tick();
        idle();
        expect_v(S_D1, "prio_a1a0_stored", 32'h2222);
        tick();
        bus.wb_en = 1'b1;
        bus.a1_tag = 5'd3; bus.m_tag = 5'd3; bus.a1_wr = 16'h2222; bus.m_wr = 16'h3333;
        expect_v(S_D1, "prio_ma1_byp", 32'h3333);
        tick();
        idle();
        bus.wb_en = 1'b1; bus.ls_tag = 5'd31; bus.ls_wr = 8'hFF;
        set_addr(5'd0, 5'd3, 5'd31, 5'd0);
        expect_v(S_D1, "prio_ma1_stored", 32'h3333);
        expect_v(S_D2, "ls31_byp", 32'h00FF);
        tick();
        idle();
        expect_v(S_D2, "ls31_stored", 32'h00FF);
        tick();

        // Issue and clear of 9 in the same cycle: set wins
        set_addr(5'd0, 5'd0, 5'd9, 5'd0);
        bus.iss_en = 1'b1; bus.iss_tag = 5'd9;
        tick();
        idle();
        expect_v(S_B2, "iss9_b2", 1); expect_v(S_CNT, "iss9_cnt", 1);
        tick();
        bus.iss_en = 1'b1; bus.iss_tag = 5'd9;
        bus.wb_en = 1'b1; bus.a0_tag = 5'd9; bus.a0_wr = 16'h0909;
        expect_v(S_B2, "setclr9_b2_now", 0); expect_v(S_D2, "setclr9_byp", 32'h0909);
        tick();
        idle();
        expect_v(S_B2, "setclr9_b2_next", 1); expect_v(S_CNT, "setclr9_cnt", 1);
        expect_v(S_D2, "setclr9_stored", 32'h0909);
        tick();

        // Stalled write-back leaves data and busy untouched
        set_addr(5'd0, 5'd0, 5'd0, 5'd4);
        bus.iss_en = 1'b1; bus.iss_tag = 5'd4;
        tick();
        idle();
        bus.a0_tag = 5'd4; bus.a0_wr = 16'h5555;
        expect_v(S_D3, "stall4_d3", 0); expect_v(S_B3, "stall4_b3", 1);
        expect_v(S_CNT, "stall4_cnt", 2);
        tick();
        idle();
        expect_v(S_D3, "stall4_d3_next", 0); expect_v(S_B3, "stall4_b3_next", 1);
        expect_v(S_CNT, "stall4_cnt_next", 2);
        tick();

        // Register 0: writes dropped, issue ignored
        set_addr(5'd0, 5'd0, 5'd0, 5'd0);
        bus.wb_en = 1'b1; bus.a0_tag = 5'd0; bus.a0_wr = 16'hFFFF;
        bus.iss_en = 1'b1; bus.iss_tag = 5'd0;
        expect_v(S_D3, "r0_byp", 0);
        tick();
        idle();
        expect_v(S_D3, "r0_stored", 0); expect_v(S_B3, "r0_busy", 0);
        expect_v(S_CNT, "r0_cnt", 2);
        tick();

        // Issue to ten registers, then reset mid-stream
        for (int i = 0; i < 10; i++) begin
            bus.iss_en = 1'b1; bus.iss_tag = TW'(11 + i);
            expect_v(S_CNT, $sformatf("burst_cnt%0d", i), 32'(2 + i));
            tick();
        end
        idle();
        set_addr(5'd11, 5'd12, 5'd20, 5'd4);
        expect_v(S_CNT, "burst_cnt_final", 12);
        expect_v(S_B0, "burst_b0", 1); expect_v(S_B1, "burst_b1", 1);
        expect_v(S_B2, "burst_b2", 1); expect_v(S_B3, "burst_b3", 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        expect_v(S_CNT, "arst_cnt", 0);
        expect_v(S_B0, "arst_b0", 0); expect_v(S_B1, "arst_b1", 0);
        expect_v(S_B2, "arst_b2", 0); expect_v(S_B3, "arst_b3", 0);
        expect_v(S_HAZ, "arst_haz", 0);
        drain();
        set_addr(5'd7, 5'd3, 5'd9, 5'd31);
        #1;
        expect_v(S_D0, "arst_d7", 0); expect_v(S_D1, "arst_d3", 0);
        expect_v(S_D2, "arst_d9", 0); expect_v(S_D3, "arst_d31", 0);
        drain();

        // No write lands on an edge with reset asserted
        bus.wb_en = 1'b1; bus.a0_tag = 5'd5; bus.a0_wr = 16'h1234;
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
        set_addr(5'd5, 5'd0, 5'd0, 5'd0);
        expect_v(S_D0, "rst_edge_nowrite", 0); expect_v(S_CNT, "rst_edge_cnt", 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
